// File: rtl/mux16_81_rr_pkg.sv
// Shared constants and types for the 8:1 16-bit gathering mux and its
// round-robin picker. The channel index type is the same 3-bit encoding the
// 1:8 demux uses as its select, so out_sel can be fed straight back.
package mux16_81_rr_pkg;

  localparam int DATA_W = 16;
  localparam int CH_N   = 8;

  // s[2] = upper group of four, s[1:0] = channel within the group
  typedef logic [2:0] ch_idx_t;

endpackage : mux16_81_rr_pkg

// File: rtl/mux16_81_rr_arb.sv
// Combinational 8-way round-robin priority picker. Searches the request
// vector starting just after last_grant and wrapping around, so the channel
// granted most recently has the lowest priority on the next pick.
module rr_arb8
  import mux16_81_rr_pkg::*;
(
  input  logic [CH_N-1:0] req,
  input  ch_idx_t         last_grant,
  output ch_idx_t         grant,
  output logic            hit
);

  // First requester in the order last_grant+1 .. last_grant+8 (mod 8)
  always_comb begin
    ch_idx_t idx;
    grant = '0;
    hit   = 1'b0;
    idx   = '0;
    for (int k = 1; k <= CH_N; k++) begin
      idx = last_grant + ch_idx_t'(k);
      if (!hit && req[idx]) begin
        grant = idx;
        hit   = 1'b1;
      end
    end
  end

endmodule : rr_arb8

// File: rtl/mux16_81_rr.sv
// Eight-into-one 16-bit gathering mux with a single registered output stage.
// Words are pulled from the source channels either round-robin or from one
// directly selected channel; each output word is tagged with its source index.
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid & ready are both 1. in_ready is combinational and at most one-hot;
// it never depends on the same channel's in_valid except through the
// arbitration result. Sources hold data/valid stable until accepted. The
// output stage may load while it drains (out_valid & out_ready), so a
// continuously ready sink receives one word per cycle.
module mux16_81_rr
  import mux16_81_rr_pkg::*;
#(
  parameter int W = DATA_W,
  parameter int N = CH_N
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W*N-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  input  logic           fix_en,
  input  logic [2:0]     fix_sel,
  output logic [W-1:0]   out_data,
  output logic [2:0]     out_sel,
  output logic           out_valid,
  input  logic           out_ready
);

  logic [W-1:0] out_data_q,  out_data_d;
  ch_idx_t      out_sel_q,   out_sel_d;
  logic         out_valid_q, out_valid_d;
  ch_idx_t      last_grant_q, last_grant_d;

  ch_idx_t rr_grant;
  logic    rr_hit;
  ch_idx_t grant;
  logic    hit;
  logic    can_load;
  logic    accept;

  rr_arb8 u_arb (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .grant      (rr_grant),
    .hit        (rr_hit)
  );

  // Pick the granted channel: fixed mode overrides the round-robin result
  always_comb begin
    can_load = !out_valid_q || out_ready;
    if (fix_en) begin
      grant = fix_sel;
      hit   = in_valid[fix_sel];
    end else begin
      grant = rr_grant;
      hit   = rr_hit;
    end
    accept = rst_n && can_load && hit;
  end

  // One-hot ready decode for the granted channel; silent while in reset
  always_comb begin
    in_ready = '0;
    if (accept) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Output stage and pointer next-state: load on accept, empty on drain
  always_comb begin
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      out_data_d   = in_data[grant*W +: W];
      out_sel_d    = grant;
      out_valid_d  = 1'b1;
      last_grant_d = grant;
    end else if (out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  // State registers; last_grant resets to 7 so channel 0 goes first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q   <= '0;
      out_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 3'd7;
    end else begin
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule : mux16_81_rr

// File: tb/tb_mux16_81_rr.sv
// Directed bench for the 8:1 gathering mux: reset, round-robin sweep,
// backpressure, sparse requests, fixed mode and asynchronous reset.
module tb_mux16_81_rr;

  logic         clk;
  logic         rst_n;
  logic [127:0] in_data;
  logic [7:0]   in_valid;
  logic [7:0]   in_ready;
  logic         fix_en;
  logic [2:0]   fix_sel;
  logic [15:0]  out_data;
  logic [2:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  int n_checks;
  int n_pass;

  mux16_81_rr dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .fix_en    (fix_en),
    .fix_sel   (fix_sel),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // checking task
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 8; i++) in_data[16*i +: 16] = 16'h1000 + 16'(i);
  endtask

  task automatic check_out(input string tag, input logic [2:0] sel, input logic [15:0] data);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_sel"},   32'(out_sel),   32'(sel));
    check({tag, "_data"},  32'(out_data),  32'(data));
  endtask

  initial begin
    logic [2:0] exp_sel;
    logic [2:0] sparse_seq [4];
    n_checks = 0;
    n_pass   = 0;

    // reset with every channel valid
    rst_n     = 1'b0;
    fix_en    = 1'b0;
    fix_sel   = 3'd0;
    out_ready = 1'b1;
    set_ramp();
    in_valid  = 8'hFF;
    #3;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data",  32'(out_data),  32'd0);
    check("rst_sel",   32'(out_sel),   32'd0);
    check("rst_ready", 32'(in_ready),  32'h00);
    tick();
    check("rst_hold_ready", 32'(in_ready), 32'h00);

    // release with only channel 3 valid
    in_valid = 8'h08;
    in_data[16*3 +: 16] = 16'hA5A3;
    rst_n = 1'b1;
    #1;
    check("rel_ready", 32'(in_ready), 32'h08);
    tick();
    check_out("rel_out", 3'd3, 16'hA5A3);
    in_valid = 8'h00;
    tick();
    check("rel_drain", 32'(out_valid), 32'd0);

    // round-robin sweep from a fresh reset: 0..7,0
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    set_ramp();
    in_valid = 8'hFF;
    #1;
    check("rr_ready0", 32'(in_ready), 32'h01);
    for (int k = 0; k < 9; k++) begin
      tick();
      exp_sel = 3'(k % 8);
      check_out("rr_out", exp_sel, 16'h1000 + 16'(exp_sel));
      check("rr_ready", 32'(in_ready), 32'(8'h01 << ((k + 1) % 8)));
    end

    // backpressure: word on channel 0 held for 5 cycles
    out_ready = 1'b0;
    #1;
    check("bp_ready", 32'(in_ready), 32'h00);
    for (int k = 0; k < 5; k++) begin
      tick();
      check_out("bp_hold", 3'd0, 16'h1000);
      check("bp_ready_hold", 32'(in_ready), 32'h00);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", 32'(in_ready), 32'h02);
    tick();
    check_out("bp_next", 3'd1, 16'h1001);

    // sparse: channels 2 and 6, pointer at 1 -> 2,6,2,6
    in_valid = 8'h44;
    sparse_seq[0] = 3'd2;
    sparse_seq[1] = 3'd6;
    sparse_seq[2] = 3'd2;
    sparse_seq[3] = 3'd6;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_out("sp_out", sparse_seq[k], 16'h1000 + 16'(sparse_seq[k]));
    end
    // single request on channel 5, granted every cycle
    in_valid = 8'h20;
    #1;
    check("sp5_ready", 32'(in_ready), 32'h20);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("sp5_out", 3'd5, 16'h1005);
      check("sp5_ready_again", 32'(in_ready), 32'h20);
    end

    // fixed mode on channel 4 with all valid
    in_valid = 8'hFF;
    fix_en   = 1'b1;
    fix_sel  = 3'd4;
    #1;
    check("fx_ready", 32'(in_ready), 32'h10);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out("fx_out", 3'd4, 16'h1004);
      check("fx_ready_again", 32'(in_ready), 32'h10);
    end
    in_valid = 8'hEF;
    #1;
    check("fx_drop_ready", 32'(in_ready), 32'h00);
    tick();
    check("fx_drain", 32'(out_valid), 32'd0);
    tick();
    check("fx_idle", 32'(out_valid), 32'd0);
    // back to round-robin: pointer carried over from 4 -> channel 5
    fix_en = 1'b0;
    #1;
    check("fx_rr_ready", 32'(in_ready), 32'h20);
    tick();
    check_out("fx_rr_out", 3'd5, 16'h1005);

    // asynchronous reset while a word is held
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(out_valid), 32'd0);
    check("ar_data",  32'(out_data),  32'd0);
    check("ar_sel",   32'(out_sel),   32'd0);
    check("ar_ready", 32'(in_ready),  32'h00);
    rst_n = 1'b1;
    in_valid = 8'hFF;
    #1;
    check("ar_restart_ready", 32'(in_ready), 32'h01);
    tick();
    check_out("ar_restart", 3'd0, 16'h1000);

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux16_81_rr
